// File: rtl/field_unpacker.sv
// rtl/field_unpacker.sv - splits one packed word into NFIELDS extended fields, one per output beat
module field_unpacker #(
  parameter int WORD_W    = 16,
  parameter int FIELD_W   = 4,
  parameter int NFIELDS   = 4,
  parameter int OUT_W     = 8,
  parameter int SIGNED    = 1,
  parameter int MSB_FIRST = 0,
  parameter int IDX_W     = (NFIELDS > 1) ? $clog2(NFIELDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_word,
  output logic              in_ready,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy
);

  localparam int HOLD_W = NFIELDS * FIELD_W;
  localparam logic [IDX_W-1:0] FIRST_IDX = (MSB_FIRST != 0) ? IDX_W'(NFIELDS - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX  = (MSB_FIRST != 0) ? '0 : IDX_W'(NFIELDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [HOLD_W-1:0]  hold, hold_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [FIELD_W-1:0] field;
  logic [OUT_W-1:0]   field_ext;
  logic               is_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      hold  <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      hold  <= hold_nxt;
      idx   <= idx_nxt;
    end
  end

  assign field   = hold[idx*FIELD_W +: FIELD_W];
  assign is_last = (idx == LAST_IDX);

  generate
    if (OUT_W > FIELD_W) begin : g_extend
      assign field_ext = {{(OUT_W-FIELD_W){(SIGNED != 0) ? field[FIELD_W-1] : 1'b0}}, field};
    end else begin : g_pass
      assign field_ext = field;
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    idx_nxt   = idx;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = EMIT;
          hold_nxt  = in_word[HOLD_W-1:0];
          idx_nxt   = FIRST_IDX;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (is_last) begin
            state_nxt = IDLE;
          end else if (MSB_FIRST != 0) begin
            idx_nxt = idx - IDX_W'(1);
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Beat fields read as zero whenever no beat is offered.
  assign out_data = out_valid ? field_ext : '0;
  assign out_idx  = out_valid ? idx : '0;
  assign out_last = out_valid && is_last;
  assign busy     = (state == EMIT);

endmodule

// File: tb/tb_field_unpacker.sv
// tb/tb_field_unpacker.sv - bench for field_unpacker across order and extension variants
module tb_field_unpacker;

  typedef struct packed {
    logic       last;
    logic [1:0] idx;
    logic [5:0] data;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [15:0] in_word;
  logic       out_ready;

  logic       ir [3];
  logic       ov [3];
  logic [5:0] od [3];
  logic [1:0] oi [3];
  logic       ol [3];
  logic       bz [3];

  int checks = 0;
  int errors = 0;

  beat_t q   [3][$];
  beat_t blog[3][$];
  bit    msb_p [3] = '{1'b0, 1'b1, 1'b0};
  bit    sgn_p [3] = '{1'b1, 1'b1, 1'b0};

  always #5 clk = ~clk;

  field_unpacker #(.WORD_W(16), .FIELD_W(4), .NFIELDS(4), .OUT_W(6), .SIGNED(1), .MSB_FIRST(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word), .in_ready(ir[0]),
    .out_valid(ov[0]), .out_data(od[0]), .out_idx(oi[0]), .out_last(ol[0]),
    .out_ready(out_ready), .busy(bz[0]));

  field_unpacker #(.WORD_W(16), .FIELD_W(4), .NFIELDS(4), .OUT_W(6), .SIGNED(1), .MSB_FIRST(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word), .in_ready(ir[1]),
    .out_valid(ov[1]), .out_data(od[1]), .out_idx(oi[1]), .out_last(ol[1]),
    .out_ready(out_ready), .busy(bz[1]));

  field_unpacker #(.WORD_W(16), .FIELD_W(4), .NFIELDS(4), .OUT_W(6), .SIGNED(0), .MSB_FIRST(0)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word), .in_ready(ir[2]),
    .out_valid(ov[2]), .out_data(od[2]), .out_idx(oi[2]), .out_last(ol[2]),
    .out_ready(out_ready), .busy(bz[2]));

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h required=%0h at %0t", name, d, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] ext(input logic [3:0] f, input bit sgn);
    int v;
    v = int'(f);
    if (sgn && v >= 8) v = v - 16;
    return v[5:0];
  endfunction

  task automatic push_word(input int d, input logic [15:0] w);
    beat_t b;
    int i;
    for (int k = 0; k < 4; k++) begin
      i = msb_p[d] ? 3 - k : k;
      b.data = ext(4'((w >> (4 * i)) & 16'hF), sgn_p[d]);
      b.idx  = 2'(i);
      b.last = (k == 3);
      q[d].push_back(b);
    end
  endtask

  // Reference: a pending-beat queue per variant; an empty queue means idle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 3; d++) q[d].delete();
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (q[d].size() > 0) begin
          if (out_ready) void'(q[d].pop_front());
        end else if (in_valid) begin
          push_word(d, in_word);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        bit ev;
        beat_t h;
        ev = q[d].size() > 0;
        h  = ev ? q[d][0] : '0;
        chk("out_valid", d, 32'(ov[d]), 32'(ev));
        chk("in_ready", d, 32'(ir[d]), 32'(!ev));
        chk("busy", d, 32'(bz[d]), 32'(ev));
        chk("out_data", d, 32'(od[d]), 32'(h.data));
        chk("out_idx", d, 32'(oi[d]), 32'(h.idx));
        chk("out_last", d, 32'(ol[d]), 32'(h.last));
        if (ov[d] && out_ready) blog[d].push_back('{last: ol[d], idx: oi[d], data: od[d]});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    for (int d = 0; d < 3; d++) blog[d].delete();
  endtask

  task automatic send(input logic [15:0] w);
    in_valid = 1'b1;
    in_word  = w;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bz[0] || bz[1] || bz[2]) && n < 30) begin
      step();
      n++;
    end
    chk("idle_timeout", 0, 32'(bz[0] || bz[1] || bz[2]), 32'd0);
  endtask

  task automatic chk_reset();
    for (int d = 0; d < 3; d++) begin
      chk("rst_in_ready", d, 32'(ir[d]), 32'd1);
      chk("rst_out_valid", d, 32'(ov[d]), 32'd0);
      chk("rst_out_data", d, 32'(od[d]), 32'd0);
      chk("rst_out_idx", d, 32'(oi[d]), 32'd0);
      chk("rst_out_last", d, 32'(ol[d]), 32'd0);
      chk("rst_busy", d, 32'(bz[d]), 32'd0);
    end
  endtask

  // Literal beat lists: data packed beat0 first in the top bits, likewise idx and last.
  task automatic expect4(input int d, input int start, input logic [23:0] datas,
                         input logic [7:0] idxs, input logic [3:0] lasts);
    chk("log_len", d, 32'(blog[d].size() >= start + 4), 32'd1);
    if (blog[d].size() >= start + 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("lit_data", d, 32'(blog[d][start+k].data), 32'(datas[23-6*k -: 6]));
        chk("lit_idx", d, 32'(blog[d][start+k].idx), 32'(idxs[7-2*k -: 2]));
        chk("lit_last", d, 32'(blog[d][start+k].last), 32'(lasts[3-k]));
      end
    end
  endtask

  task automatic expect_1a25(input int start);
    expect4(0, start, {6'h05, 6'h02, 6'h3A, 6'h01}, {2'd0, 2'd1, 2'd2, 2'd3}, 4'b0001);
    expect4(1, start, {6'h01, 6'h3A, 6'h02, 6'h05}, {2'd3, 2'd2, 2'd1, 2'd0}, 4'b0001);
    expect4(2, start, {6'h05, 6'h02, 6'h0A, 6'h01}, {2'd0, 2'd1, 2'd2, 2'd3}, 4'b0001);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_word = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset();
    rst = 1'b0;
    step();

    // Plain run at full rate.
    clear_logs();
    send(16'h1A25);
    chk("latency_valid", 0, 32'(ov[0]), 32'd1);
    chk("latency_idx", 0, 32'(oi[0]), 32'd0);
    wait_idle();
    chk("ready_after_last", 0, 32'(ir[0]), 32'd1);
    expect_1a25(0);
    step();

    // Backpressure while idx 2 is offered on the LSB-first variant.
    clear_logs();
    send(16'h1A25);
    step();
    step();
    out_ready = 1'b0;
    repeat (3) begin
      step();
      chk("bp_valid", 0, 32'(ov[0]), 32'd1);
      chk("bp_idx", 0, 32'(oi[0]), 32'd2);
      chk("bp_data", 0, 32'(od[0]), 32'h3A);
    end
    out_ready = 1'b1;
    step();
    chk("bp_next_idx", 0, 32'(oi[0]), 32'd3);
    wait_idle();
    expect_1a25(0);
    step();

    // New word offered while busy must wait for idle.
    clear_logs();
    send(16'h1A25);
    in_valid = 1'b1;
    in_word  = 16'hFFFF;
    begin
      int n;
      n = 0;
      while (!ir[0] && n < 30) begin
        step();
        n++;
      end
      chk("busy_ignore_timeout", 0, 32'(ir[0]), 32'd1);
    end
    step();
    in_valid = 1'b0;
    wait_idle();
    expect_1a25(0);
    expect4(0, 4, {4{6'h3F}}, {2'd0, 2'd1, 2'd2, 2'd3}, 4'b0001);
    expect4(1, 4, {4{6'h3F}}, {2'd3, 2'd2, 2'd1, 2'd0}, 4'b0001);
    expect4(2, 4, {4{6'h0F}}, {2'd0, 2'd1, 2'd2, 2'd3}, 4'b0001);
    chk("busy_ignore_len", 0, 32'(blog[0].size()), 32'd8);
    step();

    // Asynchronous reset mid-word.
    clear_logs();
    send(16'h1A25);
    step();
    step();
    chk("pre_rst_idx", 0, 32'(oi[0]), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_logs();
    repeat (6) step();
    chk("post_rst_no_beats", 0, 32'(blog[0].size() + blog[1].size() + blog[2].size()), 32'd0);
    chk("post_rst_ready", 0, 32'(ir[0]), 32'd1);

    // Fresh word after reset still unpacks correctly.
    send(16'h1A25);
    wait_idle();
    expect_1a25(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/field_unpacker.md
# field_unpacker

Parametrised field unpacker for the perceptron datapath. It accepts one packed word per valid/ready handshake and splits it into NFIELDS equal-width fields. The fields are emitted one per accepted beat, sign- or zero-extended to OUT_W. It generalises the fixed slice-and-load of weight/input nibbles into loadable registers: width, field count, order and extension mode are configurable, and the output side has backpressure.

## Interface
- WORD_W, 16: input word width; must satisfy WORD_W >= NFIELDS*FIELD_W.
- FIELD_W, 4: width of each field.
- NFIELDS, 4: number of fields per word; must be >= 2.
- OUT_W, 8: output width; must satisfy OUT_W >= FIELD_W.
- SIGNED, 1: 1 = sign-extend fields, 0 = zero-extend.
- MSB_FIRST, 0: 0 = emit field 0 first, 1 = emit field NFIELDS-1 first.
- IDX_W, max(1,$clog2(NFIELDS)): derived width of the index output; not overridden.

Ports (clock and reset first):
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_word is valid.
- in_word  input  WORD_W  packed word. Field i occupies bits [i*FIELD_W+FIELD_W-1 : i*FIELD_W]. Bits at and above NFIELDS*FIELD_W are ignored.
- in_ready  output  1  block can accept a word.
- out_valid  output  1  out_data is valid.
- out_data  output  OUT_W  extended field.
- out_idx  output  IDX_W  physical field index i of out_data.
- out_last  output  1  current beat is the final field of the word.
- out_ready  input  1  consumer accepts the beat.
- busy  output  1  a word is held and not yet fully emitted.

## Operation
- Two states:
  - IDLE: in_ready=1, out_valid=0.
  - EMIT: in_ready=0, out_valid=1.
- IDLE -> EMIT on in_valid && in_ready. The word is captured into the hold register, and the index counter is loaded with 0 (MSB_FIRST=0) or NFIELDS-1 (MSB_FIRST=1).
- In EMIT:
  - out_data = extend(hold[idx]).
  - out_idx = idx.
  - out_last = (idx == NFIELDS-1) for LSB-first, or (idx == 0) for MSB-first.
- Beat transfer occurs when out_valid && out_ready.
  - On a non-last transfer, idx steps by +1 (LSB-first) or -1 (MSB-first).
  - On a last transfer, return to IDLE.
- No transfer: state, idx and all outputs hold unchanged. Outputs must not glitch or change while stalled.
- in_valid is ignored while in EMIT. The upstream holds its word until in_ready.
- Extension: SIGNED=1 replicates field bit FIELD_W-1 into the upper OUT_W-FIELD_W bits. SIGNED=0 fills them with 0. When OUT_W == FIELD_W, the field passes through unchanged.
- out_data, out_idx and out_last are forced to 0 whenever out_valid=0.
- busy = (state == EMIT).
- in_ready is a pure function of state, so there is no combinational path from out_ready to in_ready.

## Timing
- Reset values: state IDLE, hold = 0, idx = 0, in_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0.
- Reset takes effect immediately and asynchronously, including mid-word. The partially emitted word is discarded and is not resumed after reset release.
- Latency: word accepted at edge N; first field valid from edge N+1.
- Throughput with out_ready held high: NFIELDS beats per word plus one IDLE cycle, i.e. NFIELDS+1 cycles per word.
- Next word: accepted at the first edge where the state is IDLE and in_valid=1, i.e. no earlier than one cycle after the last-beat transfer.
- Word handshake is sampled on the clock edge only: in_valid asserted and deasserted between edges has no effect.

## Test plan
- Parameters WORD_W=16, FIELD_W=4, NFIELDS=4, OUT_W=6, SIGNED=1, MSB_FIRST=0; in_word=16'h1A25 with out_ready=1. Required beats: (out_data, out_idx) = (6'h05,0), (6'h02,1), (6'h3A,2), (6'h01,3). out_last is set only on idx 3. in_ready returns to 1 one cycle after the last beat.
- Same word with MSB_FIRST=1. Required order: 6'h01, 6'h3A, 6'h02, 6'h05, with idx 3,2,1,0. out_last is set on idx 0.
- Same word with SIGNED=0. The field at idx 2 appears as 6'h0A; all other fields are unchanged.
- Backpressure: drop out_ready for 3 cycles while idx=2 is presented. out_data=6'h3A, out_idx=2 and out_valid=1 stay stable for those 3 cycles; idx 3 follows on the first cycle after out_ready rises.
- Busy ignore: present in_valid with 16'hFFFF while in EMIT. The word is not captured, and the current word completes with correct values. 16'hFFFF is then accepted in IDLE and yields four beats of 6'h3F.
- Reset mid-word: assert rst asynchronously after the second beat of 16'h1A25. All outputs go to their reset values without waiting for a clock edge. After release, in_ready=1 and no stale beats appear.
